carfield_apb_periph_decoder: RTL and testbench
==============================================

CARFIELD_APB_PERIPH_DECODER -- requirements
Module: carfield_apb_periph_decoder

Interface
REQ-001 SHALL have parameter CanEnable, default 1: 0 makes the CAN window unmapped, so it returns an error.
REQ-002 SHALL have parameters <T>Base/<T>Size (doub_bt) for T in {Can, SystemTimer, SystemAdvancedTimer, SystemWatchdog, HyperBus}; defaults 0x20001000, 0x20004000, 0x20005000, 0x20007000, 0x20009000, each of size 0x1000.
REQ-003 SHALL have parameter TimeoutCycles, default 256: the maximum number of downstream access cycles before the decoder aborts the transfer.
REQ-004 clk_i  input  1  single clock, rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 s_paddr_i/s_pwdata_i  input  32/32  upstream completer address and write data.
REQ-007 s_psel_i/s_penable_i/s_pwrite_i  input  1 each  upstream APB control.
REQ-008 s_pstrb_i/s_pprot_i  input  4/3  upstream write strobes and protection.
REQ-009 s_prdata_o/s_pready_o/s_pslverr_o  output  32/1/1  upstream response.
REQ-010 m_psel_o  output  5  one-hot target select, indexed 0=CAN, 1=SysTimer, 2=AdvTimer, 3=Watchdog, 4=HyperBus.
REQ-011 m_penable_o/m_pwrite_o/m_paddr_o/m_pwdata_o/m_pstrb_o/m_pprot_o  output  1/1/32/32/4/3  shared downstream bus.
REQ-012 m_prdata_i/m_pready_i/m_pslverr_i  input  5x32/5/5  per-target responses.

Function
REQ-013 SHALL use the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-014 IDLE: on s_psel_i=1 and s_penable_i=0, the decoder SHALL latch the address, write data, pwrite, pstrb and pprot, and decode the address.
- Hit on an enabled window → SETUP.
- Miss → RESP with error flag set.
REQ-015 Hit rule SHALL be Base <= paddr < Base+Size, evaluated in 33-bit arithmetic so there is no wrap at 0xFFFFFFFF; windows are disjoint, and the lowest index wins if a parameterisation makes them overlap.
REQ-016 SETUP: exactly one m_psel_o bit SHALL be 1 with m_penable_o=0 for one cycle, then → ACCESS.
REQ-017 ACCESS: the selected m_psel_o bit and m_penable_o SHALL be held at 1, and downstream address/data/control SHALL stay stable.
- On m_pready_i[sel]=1: latch m_prdata_i[sel] and m_pslverr_i[sel], then → RESP.
REQ-018 m_paddr_o SHALL equal the latched address minus the selected Base (window offset).
REQ-019 In ACCESS, a counter SHALL increment each cycle; if it reaches TimeoutCycles-1 without pready:
- drop m_psel_o/m_penable_o;
- latch prdata=0 and error=1;
- → RESP.
REQ-020 RESP: s_pready_o=1 for exactly one cycle, with s_prdata_o/s_pslverr_o from the latch, then → IDLE.
REQ-021 s_pready_o SHALL be 0 in every other state; write transfers SHALL return s_prdata_o=0.
REQ-022 Upstream latency SHALL be: hit = 3 + N cycles after the setup cycle (N = downstream wait cycles); miss = 1 cycle (RESP directly).
REQ-023 m_psel_o SHALL be all-zero outside SETUP/ACCESS; an upstream psel drop mid-transfer (protocol violation) SHALL be ignored, and the transfer SHALL complete.
REQ-024 Back-to-back: a new upstream setup SHALL be accepted in the IDLE cycle immediately following RESP.
REQ-025 m_pready_i/m_pslverr_i of non-selected targets SHALL be ignored.

Reset
REQ-026 On rst_ni=0, asynchronously:
- FSM=IDLE;
- counter=0;
- all latches=0;
- all outputs=0 (s_pready_o=0, s_pslverr_o=0, m_psel_o=5'b0, m_penable_o=0).
REQ-027 Reset mid-transfer SHALL abort it with no upstream response; the next transfer after reset release SHALL start from IDLE.

Structure
REQ-028 Target index enum, NumApbTargets=5, and default bases/sizes SHALL live in carfield_pkg; window values SHALL be drawn from the carfield_configuration address map.
REQ-029 One sub-module SHALL be instantiated: carfield_apb_addr_decode, a combinational window match that returns a one-hot hit vector plus an offset.

Verification
REQ-030 Read 0x20004010, SysTimer answers pready after 2 waits with 0xCAFE0001 → m_psel_o=5'b00010, m_paddr_o=0x10, s_prdata_o=0xCAFE0001, s_pslverr_o=0, s_pready_o asserted 5 cycles after the setup cycle.
REQ-031 Write 0x20009004 data 0x12345678 strb 0xF → HyperBus m_pwdata_o=0x12345678, m_pstrb_o=0xF, m_paddr_o=0x4; the target's pslverr=1 propagates to s_pslverr_o=1.
REQ-032 Read 0x20006000 (gap) and 0x20001000 with CanEnable=0 → no m_psel_o activity; s_pready_o one cycle later with s_pslverr_o=1 and s_prdata_o=0.
REQ-033 Watchdog never asserts pready, TimeoutCycles=8 → m_psel_o drops after 8 ACCESS cycles; s_pslverr_o=1; the next access to CAN succeeds normally.
REQ-034 rst_ni pulsed low during ACCESS → all outputs 0 immediately; s_pready_o is never asserted for the aborted transfer; the following read completes correctly.
REQ-035 Back-to-back reads to CAN then Watchdog, plus an address 0x20001FFF/0x20002000 boundary pair → correct targets selected, no idle gap beyond the one required IDLE cycle, and 0x20002000 returns an error.

Source files
------------

// File: rtl/carfield_pkg.sv
// -----------------------------------------------------------------------------
// carfield_pkg
// Shared definitions for the Carfield APB peripheral decoder:
//   - doub_bt          : 64-bit address/size type used for window parameters
//   - NumApbTargets    : number of downstream APB peripherals
//   - apb_tgt_e        : downstream target index (m_psel_o bit position)
//   - Carfield*Base/*Size : peripheral windows from the carfield_configuration
//                        address map
//   - apb_dec_state_e  : decoder FSM states
//   - window_hit()     : half-open window match helper
// -----------------------------------------------------------------------------
package carfield_pkg;

  typedef logic [63:0] doub_bt;

  localparam int unsigned NumApbTargets = 5;

  typedef enum logic [2:0] {
    ApbTgtCan      = 3'd0,
    ApbTgtSysTimer = 3'd1,
    ApbTgtAdvTimer = 3'd2,
    ApbTgtWatchdog = 3'd3,
    ApbTgtHyperBus = 3'd4
  } apb_tgt_e;

  // Peripheral windows of the carfield_configuration address map.
  localparam doub_bt CarfieldCanBase                 = 64'h0000_0000_2000_1000;
  localparam doub_bt CarfieldCanSize                 = 64'h0000_0000_0000_1000;
  localparam doub_bt CarfieldSystemTimerBase         = 64'h0000_0000_2000_4000;
  localparam doub_bt CarfieldSystemTimerSize         = 64'h0000_0000_0000_1000;
  localparam doub_bt CarfieldSystemAdvancedTimerBase = 64'h0000_0000_2000_5000;
  localparam doub_bt CarfieldSystemAdvancedTimerSize = 64'h0000_0000_0000_1000;
  localparam doub_bt CarfieldSystemWatchdogBase      = 64'h0000_0000_2000_7000;
  localparam doub_bt CarfieldSystemWatchdogSize      = 64'h0000_0000_0000_1000;
  localparam doub_bt CarfieldHyperBusBase            = 64'h0000_0000_2000_9000;
  localparam doub_bt CarfieldHyperBusSize            = 64'h0000_0000_0000_1000;

  typedef enum logic [1:0] {
    ApbIdle   = 2'd0,
    ApbSetup  = 2'd1,
    ApbAccess = 2'd2,
    ApbResp   = 2'd3
  } apb_dec_state_e;

  // Half-open match base <= addr < base+size. The compare is done in the full
  // 64-bit window type, so a window ending at 0xFFFFFFFF cannot wrap to zero.
  function automatic logic window_hit(input logic [31:0] addr,
                                      input doub_bt      base,
                                      input doub_bt      size);
    doub_bt a;
    doub_bt hi;
    a  = {32'h0000_0000, addr};
    hi = base + size;
    return (a >= base) && (a < hi);
  endfunction

endpackage

// File: rtl/carfield_apb_addr_decode.sv
// -----------------------------------------------------------------------------
// carfield_apb_addr_decode
// Combinational window match of an APB address against the peripheral map.
// Ports:
//   i_addr   [31:0]              address to decode
//   o_hit    [NumApbTargets-1:0] one-hot hit vector (all zero on a miss)
//   o_offset [31:0]              address minus base of the hit window
// Disabled windows (WinEnable bit 0) never hit. If windows overlap, the
// lowest index wins so o_hit stays one-hot.
// -----------------------------------------------------------------------------
module carfield_apb_addr_decode
  import carfield_pkg::*;
#(
  parameter doub_bt                   WinBase [NumApbTargets] = '{default: 64'h0},
  parameter doub_bt                   WinSize [NumApbTargets] = '{default: 64'h0},
  parameter logic [NumApbTargets-1:0] WinEnable               = '1
) (
  input  logic [31:0]              i_addr,
  output logic [NumApbTargets-1:0] o_hit,
  output logic [31:0]              o_offset
);

  logic w_found;

  // Priority window match: first enabled window that contains the address.
  always_comb begin
    o_hit    = '0;
    o_offset = 32'h0000_0000;
    w_found  = 1'b0;
    for (int i = 0; i < NumApbTargets; i++) begin
      if (!w_found && WinEnable[i] && window_hit(i_addr, WinBase[i], WinSize[i])) begin
        o_hit[i] = 1'b1;
        o_offset = i_addr - WinBase[i][31:0];
        w_found  = 1'b1;
      end else begin
        w_found  = w_found;
      end
    end
  end

endmodule

// File: rtl/carfield_apb_periph_decoder.sv
// -----------------------------------------------------------------------------
// carfield_apb_periph_decoder
// APB completer that forwards each upstream transfer to one of five downstream
// APB peripherals (CAN, system timer, advanced timer, watchdog, HyperBus).
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   s_paddr_i/s_pwdata_i/s_psel_i/s_penable_i/s_pwrite_i/s_pstrb_i/s_pprot_i
//                                     upstream APB request
//   s_prdata_o/s_pready_o/s_pslverr_o upstream APB response
//   m_psel_o [4:0]                    one-hot downstream select
//   m_penable_o/m_pwrite_o/m_paddr_o/m_pwdata_o/m_pstrb_o/m_pprot_o
//                                     shared downstream request (paddr is the
//                                     offset inside the selected window)
//   m_prdata_i/m_pready_i/m_pslverr_i per-target downstream responses
// Flow: IDLE latches the request and decodes; a hit goes SETUP -> ACCESS ->
// RESP, a miss goes straight to RESP with an error. ACCESS aborts with an
// error after TimeoutCycles cycles without pready.
// -----------------------------------------------------------------------------
module carfield_apb_periph_decoder
  import carfield_pkg::*;
#(
  parameter bit          CanEnable                 = 1'b1,
  parameter doub_bt      CanBase                   = CarfieldCanBase,
  parameter doub_bt      CanSize                   = CarfieldCanSize,
  parameter doub_bt      SystemTimerBase           = CarfieldSystemTimerBase,
  parameter doub_bt      SystemTimerSize           = CarfieldSystemTimerSize,
  parameter doub_bt      SystemAdvancedTimerBase   = CarfieldSystemAdvancedTimerBase,
  parameter doub_bt      SystemAdvancedTimerSize   = CarfieldSystemAdvancedTimerSize,
  parameter doub_bt      SystemWatchdogBase        = CarfieldSystemWatchdogBase,
  parameter doub_bt      SystemWatchdogSize        = CarfieldSystemWatchdogSize,
  parameter doub_bt      HyperBusBase              = CarfieldHyperBusBase,
  parameter doub_bt      HyperBusSize              = CarfieldHyperBusSize,
  parameter int unsigned TimeoutCycles             = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [31:0]                       s_paddr_i,
  input  logic [31:0]                       s_pwdata_i,
  input  logic                              s_psel_i,
  input  logic                              s_penable_i,
  input  logic                              s_pwrite_i,
  input  logic [3:0]                        s_pstrb_i,
  input  logic [2:0]                        s_pprot_i,
  output logic [31:0]                       s_prdata_o,
  output logic                              s_pready_o,
  output logic                              s_pslverr_o,
  output logic [NumApbTargets-1:0]          m_psel_o,
  output logic                              m_penable_o,
  output logic                              m_pwrite_o,
  output logic [31:0]                       m_paddr_o,
  output logic [31:0]                       m_pwdata_o,
  output logic [3:0]                        m_pstrb_o,
  output logic [2:0]                        m_pprot_o,
  input  logic [NumApbTargets-1:0][31:0]    m_prdata_i,
  input  logic [NumApbTargets-1:0]          m_pready_i,
  input  logic [NumApbTargets-1:0]          m_pslverr_i
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  localparam doub_bt WinBase [NumApbTargets] = '{CanBase, SystemTimerBase,
      SystemAdvancedTimerBase, SystemWatchdogBase, HyperBusBase};
  localparam doub_bt WinSize [NumApbTargets] = '{CanSize, SystemTimerSize,
      SystemAdvancedTimerSize, SystemWatchdogSize, HyperBusSize};
  // Disabling CAN removes its window so accesses there decode as a miss.
  localparam logic [NumApbTargets-1:0] WinEnable = {{(NumApbTargets-1){1'b1}}, CanEnable};

  apb_dec_state_e r_state;
  apb_dec_state_e w_state_next;

  logic [NumApbTargets-1:0] r_sel;
  logic [31:0]              r_offset;
  logic [31:0]              r_wdata;
  logic                     r_write;
  logic [3:0]               r_strb;
  logic [2:0]               r_prot;
  logic [31:0]              r_rdata;
  logic                     r_err;
  logic [CntW-1:0]          r_cnt;

  logic [NumApbTargets-1:0] w_hit;
  logic [31:0]              w_offset;
  logic                     w_setup;
  logic                     w_ready;
  logic                     w_slverr;
  logic                     w_timeout;
  logic [31:0]              w_prdata;

  carfield_apb_addr_decode #(
    .WinBase   (WinBase),
    .WinSize   (WinSize),
    .WinEnable (WinEnable)
  ) u_addr_decode (
    .i_addr   (s_paddr_i),
    .o_hit    (w_hit),
    .o_offset (w_offset)
  );

  // Only a true APB setup phase starts a transfer; a held access phase does not.
  assign w_setup   = s_psel_i & ~s_penable_i;
  // Responses of non-selected targets are masked out by the latched select.
  assign w_ready   = |(m_pready_i & r_sel);
  assign w_slverr  = |(m_pslverr_i & r_sel);
  assign w_timeout = (r_cnt == CntLast);

  // AND-OR read data mux over the one-hot select.
  always_comb begin
    w_prdata = 32'h0000_0000;
    for (int i = 0; i < NumApbTargets; i++) begin
      w_prdata = w_prdata | (m_prdata_i[i] & {32{r_sel[i]}});
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ApbIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ApbIdle: begin
        if (w_setup) begin
          if (|w_hit) begin
            w_state_next = ApbSetup;
          end else begin
            w_state_next = ApbResp;
          end
        end else begin
          w_state_next = ApbIdle;
        end
      end
      ApbSetup: begin
        w_state_next = ApbAccess;
      end
      ApbAccess: begin
        if (w_ready || w_timeout) begin
          w_state_next = ApbResp;
        end else begin
          w_state_next = ApbAccess;
        end
      end
      ApbResp: begin
        w_state_next = ApbIdle;
      end
      default: begin
        w_state_next = ApbIdle;
      end
    endcase
  end

  // Request latch, response latch and access-cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel    <= '0;
      r_offset <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
      r_write  <= 1'b0;
      r_strb   <= 4'h0;
      r_prot   <= 3'h0;
      r_rdata  <= 32'h0000_0000;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ApbIdle: begin
          if (w_setup) begin
            r_sel    <= w_hit;
            r_offset <= w_offset;
            r_wdata  <= s_pwdata_i;
            r_write  <= s_pwrite_i;
            r_strb   <= s_pstrb_i;
            r_prot   <= s_pprot_i;
            r_rdata  <= 32'h0000_0000;
            r_err    <= ~(|w_hit);
            r_cnt    <= '0;
          end else begin
            r_cnt    <= '0;
          end
        end
        ApbAccess: begin
          if (w_ready) begin
            // Writes return zero read data regardless of what the target drives.
            r_rdata <= r_write ? 32'h0000_0000 : w_prdata;
            r_err   <= w_slverr;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + {{(CntW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // FSM outputs, decoded from the state and the latched request/response.
  always_comb begin
    s_pready_o  = (r_state == ApbResp);
    s_prdata_o  = (r_state == ApbResp) ? r_rdata : 32'h0000_0000;
    s_pslverr_o = (r_state == ApbResp) ? r_err : 1'b0;
    m_psel_o    = ((r_state == ApbSetup) || (r_state == ApbAccess)) ? r_sel : '0;
    m_penable_o = (r_state == ApbAccess);
    m_pwrite_o  = r_write;
    m_paddr_o   = r_offset;
    m_pwdata_o  = r_wdata;
    m_pstrb_o   = r_strb;
    m_pprot_o   = r_prot;
  end

endmodule

// File: tb/tb_carfield_apb_periph_decoder.sv
module tb_carfield_apb_periph_decoder;
  import carfield_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s_paddr = 32'h0, s_pwdata = 32'h0;
  logic        s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
  logic [3:0]  s_pstrb = 4'h0;
  logic [2:0]  s_pprot = 3'h0;

  logic [31:0] s_prdata;
  logic        s_pready, s_pslverr;
  logic [4:0]  m_psel;
  logic        m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic [3:0]  m_pstrb;
  logic [2:0]  m_pprot;
  logic [4:0][31:0] m_prdata;
  logic [4:0]  m_pready, m_pslverr;

  logic [31:0] nc_prdata;
  logic        nc_pready, nc_pslverr;
  logic [4:0]  nc_psel;
  logic        nc_penable, nc_pwrite;
  logic [31:0] nc_paddr, nc_pwdata;
  logic [3:0]  nc_pstrb;
  logic [2:0]  nc_pprot;
  logic [4:0][31:0] nc_m_prdata;
  assign nc_m_prdata = {5{32'h5555_AAAA}};

  int          tgt_wait [5];
  logic [31:0] tgt_rdata [5];
  logic        tgt_err [5];
  int          acc_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t exp_q[$];
  exp_t e;

  logic [31:0] obs_rdata, obs_paddr, obs_pwdata;
  logic        obs_err, obs_pwrite, obs_unstable, obs_done;
  logic [3:0]  obs_pstrb;
  logic [4:0]  obs_psel;
  int          obs_lat, obs_acc, obs_start, obs_resp;
  logic [4:0]  nc_psel_seen;
  logic        nc_done, nc_err_obs;
  logic [31:0] nc_rdata_obs;
  int          nc_lat;

  carfield_apb_periph_decoder #(.TimeoutCycles(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_psel_i(s_psel),
    .s_penable_i(s_penable), .s_pwrite_i(s_pwrite), .s_pstrb_i(s_pstrb),
    .s_pprot_i(s_pprot), .s_prdata_o(s_prdata), .s_pready_o(s_pready),
    .s_pslverr_o(s_pslverr), .m_psel_o(m_psel), .m_penable_o(m_penable),
    .m_pwrite_o(m_pwrite), .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata),
    .m_pstrb_o(m_pstrb), .m_pprot_o(m_pprot), .m_prdata_i(m_prdata),
    .m_pready_i(m_pready), .m_pslverr_i(m_pslverr)
  );

  carfield_apb_periph_decoder #(.CanEnable(1'b0)) u_dut_nocan (
    .clk_i(clk), .rst_ni(rst_n),
    .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_psel_i(s_psel),
    .s_penable_i(s_penable), .s_pwrite_i(s_pwrite), .s_pstrb_i(s_pstrb),
    .s_pprot_i(s_pprot), .s_prdata_o(nc_prdata), .s_pready_o(nc_pready),
    .s_pslverr_o(nc_pslverr), .m_psel_o(nc_psel), .m_penable_o(nc_penable),
    .m_pwrite_o(nc_pwrite), .m_paddr_o(nc_paddr), .m_pwdata_o(nc_pwdata),
    .m_pstrb_o(nc_pstrb), .m_pprot_o(nc_pprot), .m_prdata_i(nc_m_prdata),
    .m_pready_i(5'b11111), .m_pslverr_i(5'b00000)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream target model: selected target answers after tgt_wait access
  // cycles (negative = never); unselected targets drive ready/error garbage.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (m_penable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    m_pready  = 5'b00000;
    m_pslverr = 5'b00000;
    m_prdata  = '0;
    for (int i = 0; i < 5; i++) begin
      m_prdata[i] = tgt_rdata[i];
      if (m_psel[i]) begin
        m_pready[i]  = m_penable && (tgt_wait[i] >= 0) && (acc_cnt == tgt_wait[i]);
        m_pslverr[i] = tgt_err[i];
      end else begin
        m_pready[i]  = 1'b1;
        m_pslverr[i] = 1'b1;
      end
    end
  end

  // One upstream transfer; records what both DUTs did. Leaves the access phase
  // driven so a following call can start a back-to-back transfer.
  task automatic do_apb(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb);
    @(posedge clk); #1;
    s_paddr = addr; s_pwrite = wr; s_pwdata = wdata; s_pstrb = strb;
    s_pprot = 3'b010; s_psel = 1'b1; s_penable = 1'b0;
    obs_start = cyc; obs_lat = 0; obs_acc = 0; obs_done = 1'b0;
    obs_psel = 5'b0; obs_unstable = 1'b0; obs_rdata = 32'hX; obs_err = 1'bX;
    nc_done = 1'b0; nc_psel_seen = 5'b0; nc_lat = 0;
    for (int i = 0; i < 200 && !obs_done; i++) begin
      @(posedge clk); #1;
      obs_lat++;
      if (obs_lat == 1) s_penable = 1'b1;
      obs_psel = obs_psel | m_psel;
      nc_psel_seen = nc_psel_seen | nc_psel;
      if (m_penable) begin
        if (obs_acc == 0) begin
          obs_paddr = m_paddr; obs_pwdata = m_pwdata;
          obs_pstrb = m_pstrb; obs_pwrite = m_pwrite;
        end else if (m_paddr !== obs_paddr || m_pwdata !== obs_pwdata || m_psel !== obs_psel) begin
          obs_unstable = 1'b1;
        end
        obs_acc++;
      end
      if (!nc_done && nc_pready) begin
        nc_done = 1'b1; nc_lat = obs_lat; nc_err_obs = nc_pslverr; nc_rdata_obs = nc_prdata;
      end
      if (s_pready) begin
        obs_done = 1'b1; obs_rdata = s_prdata; obs_err = s_pslverr; obs_resp = cyc;
      end
    end
    if (!obs_done) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no s_pready_o for addr %h within 200 cycles", addr);
    end
  endtask

  task automatic bus_idle();
    s_psel = 1'b0; s_penable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_resp(input string name);
    e = exp_q.pop_front();
    checks++;
    if (obs_rdata !== e.rdata) begin errors++; $display("FAIL %s rdata: got %h expected %h", name, obs_rdata, e.rdata); end
    checks++;
    if (obs_err !== e.err) begin errors++; $display("FAIL %s pslverr: got %b expected %b", name, obs_err, e.err); end
    checks++;
    if (obs_lat !== int'(e.lat)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, obs_lat, e.lat); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({s_pready, s_pslverr, m_psel, m_penable, s_prdata} !== 40'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {s_pready, s_pslverr, m_psel, m_penable, s_prdata});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_pready, s_pslverr, m_psel, m_penable} !== 8'h0) begin
      errors++; $display("FAIL reset_held: got %h expected 0", {s_pready, s_pslverr, m_psel, m_penable});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_systimer_read();
    tgt_wait[1] = 2; tgt_rdata[1] = 32'hCAFE_0001; tgt_err[1] = 1'b0;
    exp_q.push_back('{rdata: 32'hCAFE_0001, err: 1'b0, lat: 32'd5});
    do_apb(32'h2000_4010, 1'b0, 32'h0, 4'h0);
    checks++;
    if (obs_psel !== 5'b00010) begin errors++; $display("FAIL systimer psel: got %b expected 00010", obs_psel); end
    checks++;
    if (obs_paddr !== 32'h10) begin errors++; $display("FAIL systimer paddr: got %h expected 00000010", obs_paddr); end
    checks++;
    if (obs_acc !== 3) begin errors++; $display("FAIL systimer access_cycles: got %0d expected 3", obs_acc); end
    check_resp("systimer");
    bus_idle();
  endtask

  task automatic test_hyperbus_write();
    tgt_wait[4] = 0; tgt_rdata[4] = 32'hBEEF_BEEF; tgt_err[4] = 1'b1;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 32'd3});
    do_apb(32'h2000_9004, 1'b1, 32'h1234_5678, 4'hF);
    checks++;
    if ({obs_psel, obs_pwrite, obs_pstrb} !== {5'b10000, 1'b1, 4'hF}) begin
      errors++; $display("FAIL hyper ctrl: got psel=%b pwrite=%b strb=%h expected 10000/1/f", obs_psel, obs_pwrite, obs_pstrb);
    end
    checks++;
    if (obs_pwdata !== 32'h1234_5678) begin errors++; $display("FAIL hyper pwdata: got %h expected 12345678", obs_pwdata); end
    checks++;
    if (obs_paddr !== 32'h4) begin errors++; $display("FAIL hyper paddr: got %h expected 00000004", obs_paddr); end
    check_resp("hyper");
    bus_idle();
  endtask

  task automatic test_miss_gap();
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 32'd1});
    do_apb(32'h2000_6000, 1'b0, 32'h0, 4'h0);
    checks++;
    if (obs_psel !== 5'b0) begin errors++; $display("FAIL gap psel: got %b expected 00000", obs_psel); end
    check_resp("gap");
    bus_idle();
  endtask

  task automatic test_can_disabled();
    tgt_wait[0] = 0; tgt_rdata[0] = 32'h0C0A_0000; tgt_err[0] = 1'b0;
    exp_q.push_back('{rdata: 32'h0C0A_0000, err: 1'b0, lat: 32'd3});
    do_apb(32'h2000_1000, 1'b0, 32'h0, 4'h0);
    check_resp("can_en");
    checks++;
    if (nc_psel_seen !== 5'b0) begin errors++; $display("FAIL can_dis psel: got %b expected 00000", nc_psel_seen); end
    checks++;
    if ({nc_done, nc_lat[7:0], nc_err_obs, nc_rdata_obs} !== {1'b1, 8'd1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL can_dis resp: got done=%b lat=%0d err=%b rdata=%h expected 1/1/1/0", nc_done, nc_lat, nc_err_obs, nc_rdata_obs);
    end
    bus_idle();
  endtask

  task automatic test_timeout();
    tgt_wait[3] = -1; tgt_rdata[3] = 32'h7777_7777; tgt_err[3] = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 32'd10});
    do_apb(32'h2000_7008, 1'b0, 32'h0, 4'h0);
    checks++;
    if (obs_acc !== 8) begin errors++; $display("FAIL wdt access_cycles: got %0d expected 8", obs_acc); end
    checks++;
    if (obs_unstable !== 1'b0) begin errors++; $display("FAIL wdt stable: got %b expected 0", obs_unstable); end
    check_resp("wdt_timeout");
    checks++;
    if (m_psel !== 5'b0) begin errors++; $display("FAIL wdt psel_drop: got %b expected 00000", m_psel); end
    bus_idle();
    tgt_wait[0] = 1; tgt_rdata[0] = 32'hA5A5_0000;
    exp_q.push_back('{rdata: 32'hA5A5_0000, err: 1'b0, lat: 32'd4});
    do_apb(32'h2000_1020, 1'b0, 32'h0, 4'h0);
    check_resp("can_after_to");
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic seen_ready;
    tgt_wait[1] = 6; tgt_rdata[1] = 32'h1111_2222;
    @(posedge clk); #1;
    s_paddr = 32'h2000_4020; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge clk); #1; s_penable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({m_psel, m_penable} !== 6'b00010_1) begin errors++; $display("FAIL rstmid in_access: got %b expected 000101", {m_psel, m_penable}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_pready, s_pslverr, m_psel, m_penable, s_prdata} !== 40'h0) begin
      errors++; $display("FAIL rstmid outputs: got %h expected 0", {s_pready, s_pslverr, m_psel, m_penable, s_prdata});
    end
    seen_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    s_psel = 1'b0; s_penable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen_ready = seen_ready | s_pready;
    end
    checks++;
    if (seen_ready !== 1'b0) begin errors++; $display("FAIL rstmid no_resp: got %b expected 0", seen_ready); end
    tgt_wait[1] = 0; tgt_rdata[1] = 32'h3333_4444;
    exp_q.push_back('{rdata: 32'h3333_4444, err: 1'b0, lat: 32'd3});
    do_apb(32'h2000_4000, 1'b0, 32'h0, 4'h0);
    check_resp("after_rst");
    bus_idle();
  endtask

  task automatic test_back_to_back();
    int prev_resp;
    tgt_wait[0] = 0; tgt_rdata[0] = 32'h0000_CA00;
    tgt_wait[3] = 0; tgt_rdata[3] = 32'h0000_3D00; tgt_err[3] = 1'b0;
    exp_q.push_back('{rdata: 32'h0000_CA00, err: 1'b0, lat: 32'd3});
    do_apb(32'h2000_1004, 1'b0, 32'h0, 4'h0);
    check_resp("b2b_can");
    prev_resp = obs_resp;
    exp_q.push_back('{rdata: 32'h0000_3D00, err: 1'b0, lat: 32'd3});
    do_apb(32'h2000_7000, 1'b0, 32'h0, 4'h0);
    checks++;
    if (obs_psel !== 5'b01000) begin errors++; $display("FAIL b2b_wdt psel: got %b expected 01000", obs_psel); end
    checks++;
    if (obs_resp - prev_resp !== 4) begin errors++; $display("FAIL b2b gap: got %0d expected 4", obs_resp - prev_resp); end
    check_resp("b2b_wdt");
    exp_q.push_back('{rdata: 32'h0000_CA00, err: 1'b0, lat: 32'd3});
    do_apb(32'h2000_1FFF, 1'b0, 32'h0, 4'h0);
    checks++;
    if ({obs_psel, obs_paddr} !== {5'b00001, 32'h0000_0FFF}) begin
      errors++; $display("FAIL edge_in target: got psel=%b paddr=%h expected 00001/00000fff", obs_psel, obs_paddr);
    end
    check_resp("edge_in");
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 32'd1});
    do_apb(32'h2000_2000, 1'b0, 32'h0, 4'h0);
    checks++;
    if (obs_psel !== 5'b0) begin errors++; $display("FAIL edge_out psel: got %b expected 00000", obs_psel); end
    check_resp("edge_out");
    bus_idle();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      tgt_wait[i] = 0; tgt_rdata[i] = 32'hD000_0000 | i; tgt_err[i] = 1'b0;
    end
    test_reset();
    test_systimer_read();
    test_hyperbus_write();
    test_miss_gap();
    test_can_disabled();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
